// File: rtl/ndro_pulse_checker.sv
// Observer/checker for a toggle-pulse NDRO cell: models the stored bit and flags
// setup, hold, conflict and out-window violations. Optional macro: NDRO_CHK_STICKY_EN.
module ndro_pulse_checker #(
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 3,
  parameter int OUT_WIN   = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             reset,
  input  logic             ndro_clk,
  input  logic             out,
  output logic             state_o,
  output logic             viol_setup,
  output logic             viol_hold,
  output logic             viol_conflict,
  output logic             viol_out,
  output logic [CNT_W-1:0] err_count
);
  localparam int SAT = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int SW  = $clog2(SAT + 2);
  localparam int AW  = $clog2(OUT_WIN + 1);

  logic          prev_set, prev_reset, prev_clk, prev_out;
  logic [SW-1:0] since_sr, since_clk;
  logic          win_open;
  logic [AW-1:0] win_age;

  logic ev_set, ev_reset, ev_clk, ev_out, ev_sr;
  logic n_setup, n_hold, n_conflict, n_out;
  logic out_ok, expire, missing, spurious;
  logic [2:0]       n_sum;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    ev_set     = set ^ prev_set;
    ev_reset   = reset ^ prev_reset;
    ev_clk     = ndro_clk ^ prev_clk;
    ev_out     = out ^ prev_out;
    ev_sr      = ev_set | ev_reset;
    n_conflict = ev_set & ev_reset;
    // a same-cycle set/reset is distance 0: setup only, never hold
    n_setup    = ev_clk & (ev_sr | (since_sr < SW'(SETUP_CYC)));
    n_hold     = ev_sr & ~ev_clk & (since_clk < SW'(HOLD_CYC));
    out_ok     = win_open & ev_out;
    expire     = win_open & ~ev_out & (win_age == AW'(OUT_WIN));
    missing    = win_open & ~ev_out & ev_clk & ~expire;
    spurious   = ev_out & ~win_open;
    n_out      = spurious | expire | missing;
    n_sum      = 3'(n_setup) + 3'(n_hold) + 3'(n_conflict) + 3'(n_out);
    cnt_sum    = {1'b0, err_count} + (CNT_W+1)'(n_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_set      <= set;
      prev_reset    <= reset;
      prev_clk      <= ndro_clk;
      prev_out      <= out;
      since_sr      <= SW'(SAT);
      since_clk     <= SW'(SAT);
      win_open      <= 1'b0;
      win_age       <= '0;
      state_o       <= 1'b0;
      viol_setup    <= 1'b0;
      viol_hold     <= 1'b0;
      viol_conflict <= 1'b0;
      viol_out      <= 1'b0;
      err_count     <= '0;
    end else begin
      prev_set   <= set;
      prev_reset <= reset;
      prev_clk   <= ndro_clk;
      prev_out   <= out;

      if (ev_sr)                     since_sr <= SW'(1);
      else if (since_sr != SW'(SAT)) since_sr <= since_sr + SW'(1);
      if (ev_clk)                     since_clk <= SW'(1);
      else if (since_clk != SW'(SAT)) since_clk <= since_clk + SW'(1);

      if (ev_set && !ev_reset)      state_o <= 1'b1;
      else if (ev_reset && !ev_set) state_o <= 1'b0;

      // readout sees the stored bit from before this cycle's set/reset
      if (ev_clk) begin
        win_open <= state_o;
        win_age  <= AW'(1);
      end else if (out_ok || expire) begin
        win_open <= 1'b0;
      end else if (win_open) begin
        win_age  <= win_age + AW'(1);
      end

`ifdef NDRO_CHK_STICKY_EN
      viol_setup    <= viol_setup    | n_setup;
      viol_hold     <= viol_hold     | n_hold;
      viol_conflict <= viol_conflict | n_conflict;
      viol_out      <= viol_out      | n_out;
`else
      viol_setup    <= n_setup;
      viol_hold     <= n_hold;
      viol_conflict <= n_conflict;
      viol_out      <= n_out;
`endif
      err_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end
endmodule
